// File: rtl/spart_pkg.sv
// ---------------------------------------------------------------------------
// spart_pkg
//
// Shared definitions for the SPART transmit sequencer and its watchdog.
//
// Contents:
//   state_t          - sequencer state encoding (3 bits)
//   SEL_LO / SEL_HI  - byte-mux select values (low byte / high byte)
//   TIMEOUT_DEFAULT  - default number of cycles a SEND state may wait for tbr
//   TIMEOUT_W        - counter width for the default timeout
//   is_send_state()  - true for the two states that may issue a write strobe
// ---------------------------------------------------------------------------
package spart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEND_LO = 3'd1,
        ST_GAP_LO  = 3'd2,
        ST_SEND_HI = 3'd3,
        ST_GAP_HI  = 3'd4
    } state_t;

    localparam logic SEL_LO = 1'b0;
    localparam logic SEL_HI = 1'b1;

    localparam int TIMEOUT_DEFAULT = 1024;
    localparam int TIMEOUT_W       = $clog2(TIMEOUT_DEFAULT);

    // The SEND states are the only ones that look at tbr and can strobe
    // the transmitter, so several decodes hinge on this test.
    function automatic logic is_send_state(input state_t s);
        return (s == ST_SEND_LO) || (s == ST_SEND_HI);
    endfunction

endpackage

// File: rtl/spart_tx_watchdog.sv
// ---------------------------------------------------------------------------
// spart_tx_watchdog
//
// Timeout counter for the SPART transmit sequencer. Counts cycles spent in
// a SEND state while the transmitter is not ready, and flags a timeout on
// the cycle the count reaches TIMEOUT_CYCLES-1 with the transmitter still
// not ready. Only instantiated when SPART_TX_TIMEOUT_EN is defined.
//
// Parameters:
//   TIMEOUT_CYCLES - number of stalled SEND cycles before the timeout fires
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset, clears the count
//   clear    in   sequencer is entering a SEND state this cycle
//   cnt_en   in   sequencer is in a SEND state and tbr is low
//   timeout  out  combinational: abort the current SEND this cycle
// ---------------------------------------------------------------------------
module spart_tx_watchdog
    import spart_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic cnt_en,
    output logic timeout
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Entry into a SEND state restarts the count; entry and a stalled SEND
    // cycle never coincide because SEND states are only entered from IDLE
    // or GAP_LO. The count also restarts after a timeout so a stale value
    // never carries into the next transfer.
    always_comb begin
        cnt_d = cnt_q;
        if (clear || timeout) begin
            cnt_d = '0;
        end else if (cnt_en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign timeout = cnt_en && (cnt_q == CNT_LAST);

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spart_tx_seq.sv
// ---------------------------------------------------------------------------
// spart_tx_seq
//
// Streams a 16-bit operand out through the byte-wide SPART transmit path.
// A single-cycle req captures p1 and the word flag, then the sequencer
// sends the low byte and, for word transfers, the high byte, each paced by
// tbr. A one-cycle gap follows every write because SPART drops tbr the
// cycle after it is written. The pipeline is stalled for the whole
// transfer.
//
// Optional feature (macro SPART_TX_TIMEOUT_EN):
//   Defined   - a watchdog aborts a SEND state that waits TIMEOUT_CYCLES
//               cycles for tbr; err is set (sticky until the next accepted
//               req or rst) and no done pulse is issued.
//   Undefined - SEND states wait indefinitely and err is tied to 0.
//
// Parameters:
//   TIMEOUT_CYCLES - SEND-state wait limit, used only with the watchdog
//
// Ports:
//   clk     in   system clock
//   rst     in   synchronous active-high reset
//   req     in   single-cycle transmit request from execute
//   word    in   1 = send both bytes, 0 = low byte only (sampled with req)
//   p1      in   16-bit operand (sampled with req)
//   tbr     in   SPART transmit buffer ready
//   data_o  out  captured operand, stable for the transfer
//   sel     out  byte select: 0 = data_o[7:0], 1 = data_o[15:8] (registered)
//   tx_wr   out  write strobe to SPART (combinational)
//   stall   out  pipeline hold, high whenever not IDLE (combinational)
//   done    out  one-cycle completion pulse (registered)
//   err     out  sticky timeout flag (registered)
// ---------------------------------------------------------------------------
module spart_tx_seq
    import spart_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        word,
    input  logic [15:0] p1,
    input  logic        tbr,
    output logic [15:0] data_o,
    output logic        sel,
    output logic        tx_wr,
    output logic        stall,
    output logic        done,
    output logic        err
);

    state_t      state_q;
    state_t      state_d;
    logic [15:0] data_q;
    logic [15:0] data_d;
    logic        word_q;
    logic        word_d;
    logic        sel_q;
    logic        sel_d;
    logic        done_q;
    logic        done_d;
    logic        timeout;

`ifdef SPART_TX_TIMEOUT_EN
    logic        err_q;
    logic        err_d;
    logic        wd_clear;
    logic        wd_cnt_en;

    // Restart the count on every entry into a SEND state; count only the
    // SEND cycles in which the transmitter is not ready.
    assign wd_clear  = is_send_state(state_d) && (state_d != state_q);
    assign wd_cnt_en = is_send_state(state_q) && !tbr;

    spart_tx_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .cnt_en  (wd_cnt_en),
        .timeout (timeout)
    );

    // err is cleared by an accepted request and set by an abort; the two
    // cannot happen in the same cycle since aborts occur only in SEND states.
    always_comb begin
        err_d = err_q;
        if ((state_q == ST_IDLE) && req) begin
            err_d = 1'b0;
        end else if (timeout) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic        unused_timeout_cfg;

    // Without the watchdog a SEND state never gives up waiting for tbr.
    assign timeout            = 1'b0;
    assign err                = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

    // Next-state and next-output logic. Operand and word flag are captured
    // only when a request is accepted in IDLE, so requests that arrive while
    // the pipeline is stalled leave data_o untouched.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        word_d  = word_q;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_SEND_LO;
                    data_d  = p1;
                    word_d  = word;
                end
            end
            ST_SEND_LO: begin
                if (tbr) begin
                    state_d = ST_GAP_LO;
                end else if (timeout) begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP_LO: begin
                // tbr is not looked at here: SPART drops it after a write.
                state_d = word_q ? ST_SEND_HI : ST_IDLE;
            end
            ST_SEND_HI: begin
                if (tbr) begin
                    state_d = ST_GAP_HI;
                end else if (timeout) begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP_HI: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // sel and done are registered decodes of the state being entered,
        // so they line up with that state's cycle.
        sel_d  = ((state_d == ST_SEND_HI) || (state_d == ST_GAP_HI)) ? SEL_HI : SEL_LO;
        done_d = (state_d == ST_GAP_HI) || ((state_d == ST_GAP_LO) && !word_d);
    end

    // State and registered outputs, synchronous reset. A reset in any state
    // returns to IDLE at the next edge, which also kills tx_wr immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            word_q  <= 1'b0;
            sel_q   <= SEL_LO;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            word_q  <= word_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
        end
    end

    assign data_o = data_q;
    assign sel    = sel_q;
    assign done   = done_q;
    assign tx_wr  = is_send_state(state_q) && tbr;
    assign stall  = (state_q != ST_IDLE);

endmodule
